// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory-bus arbiter.
// Holds the arbiter state encoding, default parameter values and the grant decode.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_e;

  localparam int unsigned TIMEOUT_DEF  = 255;
  localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

  // Wide enough for the full 1..65535 TIMEOUT range.
  localparam int CNT_W = 16;

  localparam logic LAST_M0 = 1'b0;
  localparam logic LAST_M1 = 1'b1;

  function automatic logic [1:0] grant_onehot(input arb_state_e st);
    logic [1:0] g;
    g = 2'b00;
    case (st)
      BUSY0:   g = 2'b01;
      BUSY1:   g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bus_timeout.sv
// Slave-wait counter: cleared while idle, counts stalled BUSY cycles and flags
// the terminal count TIMEOUT-1 combinationally.
module bus_timeout
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == TERM);

endmodule

// File: rtl/mem_arbiter2.sv
// Two-master round-robin arbiter onto one valid/ready memory slave, with a
// slave-wait timeout that completes the transfer with ERR_DATA and a bus_err pulse.
module mem_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,

  output logic [1:0]  grant,
  output logic        bus_err
);

  arb_state_e  state_q, state_d;
  logic        last_q, last_d;

  logic        busy;
  logic        own1;
  logic        sel_valid;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;

  logic        tmr_clr;
  logic        tmr_en;
  logic        tmr_expired;

  logic        rsp_rdy;
  logic [31:0] rsp_data;
  logic        xfer_end;

  assign busy = (state_q != IDLE);
  assign own1 = (state_q == BUSY1);

  assign sel_valid = own1 ? m1_valid : m0_valid;
  assign sel_addr  = own1 ? m1_addr  : m0_addr;
  assign sel_wdata = own1 ? m1_wdata : m0_wdata;
  assign sel_wstrb = own1 ? m1_wstrb : m0_wstrb;

  // Counter restarts every time the arbiter passes through IDLE.
  assign tmr_clr = reset | ~busy;
  assign tmr_en  = busy & sel_valid & ~s_ready;

  bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LAST_M1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          if (last_q == LAST_M1) begin
            state_d = BUSY0;
            last_d  = LAST_M0;
          end else begin
            state_d = BUSY1;
            last_d  = LAST_M1;
          end
        end else if (m0_valid) begin
          state_d = BUSY0;
          last_d  = LAST_M0;
        end else if (m1_valid) begin
          state_d = BUSY1;
          last_d  = LAST_M1;
        end
      end
      BUSY0, BUSY1: begin
        if (xfer_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    grant    = grant_onehot(state_q);
    rsp_rdy  = 1'b0;
    rsp_data = '0;
    bus_err  = 1'b0;
    xfer_end = 1'b0;
    if (busy) begin
      s_valid = sel_valid;
      s_addr  = sel_addr;
      s_wdata = sel_wdata;
      s_wstrb = sel_wstrb;
      // A dropped request abandons the transfer without a response.
      if (!sel_valid) begin
        xfer_end = 1'b1;
      end else if (s_ready) begin
        rsp_rdy  = 1'b1;
        rsp_data = s_rdata;
        xfer_end = 1'b1;
      end else if (tmr_expired) begin
        rsp_rdy  = 1'b1;
        rsp_data = ERR_DATA;
        bus_err  = 1'b1;
        xfer_end = 1'b1;
      end
    end
    // Reset aborts an in-flight transfer with no handshake visible to the master.
    if (reset) begin
      rsp_rdy  = 1'b0;
      rsp_data = '0;
      bus_err  = 1'b0;
    end
  end

  assign m0_ready = rsp_rdy & ~own1;
  assign m1_ready = rsp_rdy &  own1;
  assign m0_rdata = m0_ready ? rsp_data : '0;
  assign m1_rdata = m1_ready ? rsp_data : '0;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level owner/wait model.
module tb_mem_arbiter2;

  localparam int TO = 4;
  localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_arbiter2 #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .bus_err(bus_err)
  );

  int errors = 0;
  int checks = 0;

  // Model: which master owns the bus (-1 none), cycles it has waited, last winner.
  int m_owner, m_wait, m_last;
  logic [1:0]  e_grant;
  logic        e_svalid, e_rdy0, e_rdy1, e_err, e_done;
  logic [31:0] e_saddr, e_swdata, e_rd0, e_rd1;
  logic [3:0]  e_swstrb;

  int n_g0, n_g1, n_r0, n_r1, n_err;
  logic [31:0] cap_rd0, cap_rd1, cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic [1:0]  glog[$];

  localparam logic [1:0] EXP31 [13] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00,
                                        2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
  localparam logic [1:0] EXP35 [5] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    logic v;
    logic [31:0] rd;
    e_grant = 2'b00; e_svalid = 1'b0; e_saddr = '0; e_swdata = '0; e_swstrb = '0;
    e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_rd0 = '0; e_rd1 = '0; e_err = 1'b0; e_done = 1'b0;
    rd = '0;
    if (m_owner >= 0) begin
      v        = (m_owner == 1) ? m1_valid : m0_valid;
      e_svalid = v;
      e_saddr  = (m_owner == 1) ? m1_addr  : m0_addr;
      e_swdata = (m_owner == 1) ? m1_wdata : m0_wdata;
      e_swstrb = (m_owner == 1) ? m1_wstrb : m0_wstrb;
      e_grant  = (m_owner == 1) ? 2'b10 : 2'b01;
      if (!v) e_done = 1'b1;
      else if (s_ready) begin
        e_done = 1'b1; rd = s_rdata;
        if (m_owner == 1) e_rdy1 = 1'b1; else e_rdy0 = 1'b1;
      end else if (m_wait == TO - 1) begin
        e_done = 1'b1; rd = ERRD; e_err = 1'b1;
        if (m_owner == 1) e_rdy1 = 1'b1; else e_rdy0 = 1'b1;
      end
    end
    if (reset) begin
      e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_err = 1'b0;
    end
    if (e_rdy0) e_rd0 = rd;
    if (e_rdy1) e_rd1 = rd;
  endtask

  task automatic model_advance();
    if (reset) begin
      m_owner = -1; m_last = 1; m_wait = 0;
    end else if (m_owner < 0) begin
      if (m0_valid && m1_valid) m_owner = 1 - m_last;
      else if (m0_valid)        m_owner = 0;
      else if (m1_valid)        m_owner = 1;
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_wait = 0;
      end
    end else if (e_done) begin
      m_owner = -1;
    end else begin
      m_wait++;
    end
  endtask

  task automatic reset_mon();
    n_g0 = 0; n_g1 = 0; n_r0 = 0; n_r1 = 0; n_err = 0;
    cap_rd0 = '0; cap_rd1 = '0; cap_addr = '0; cap_wdata = '0; cap_wstrb = '0;
    glog.delete();
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    chk("grant",    32'(grant),    32'(e_grant));
    chk("s_valid",  32'(s_valid),  32'(e_svalid));
    chk("s_addr",   s_addr,        e_saddr);
    chk("s_wdata",  s_wdata,       e_swdata);
    chk("s_wstrb",  32'(s_wstrb),  32'(e_swstrb));
    chk("m0_ready", 32'(m0_ready), 32'(e_rdy0));
    chk("m1_ready", 32'(m1_ready), 32'(e_rdy1));
    chk("m0_rdata", m0_rdata,      e_rd0);
    chk("m1_rdata", m1_rdata,      e_rd1);
    chk("bus_err",  32'(bus_err),  32'(e_err));
    glog.push_back(grant);
    if (grant == 2'b01) n_g0++;
    if (grant == 2'b10) n_g1++;
    if (m0_ready) begin n_r0++; cap_rd0 = m0_rdata; end
    if (m1_ready) begin n_r1++; cap_rd1 = m1_rdata; end
    if (bus_err) n_err++;
    if (s_valid) begin cap_addr = s_addr; cap_wdata = s_wdata; cap_wstrb = s_wstrb; end
    @(posedge clk);
    model_advance();
    #1;
  endtask

  initial begin
    int rem0, rem1;
    reset = 1'b1;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 1'b0; s_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_owner = -1; m_last = 1; m_wait = 0;

    // Post-reset idle outputs
    reset_mon();
    cycle(); cycle();
    chk("reset_idle_grants", 32'(n_g0 + n_g1), 32'd0);

    // m0 read, slave answers on the 4th BUSY cycle (also the TIMEOUT-1 boundary)
    reset_mon();
    m0_valid = 1'b1; m0_addr = 32'h0000_1000; m0_wstrb = 4'b0000; m0_wdata = '0;
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
    cycle();
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    cycle();
    chk("rd_grant01_cycles", 32'(n_g0), 32'd4);
    chk("rd_m0_ready_pulses", 32'(n_r0), 32'd1);
    chk("rd_m0_rdata", cap_rd0, 32'hDEAD_BEEF);
    chk("rd_m1_ready_pulses", 32'(n_r1), 32'd0);
    chk("rd_boundary_no_err", 32'(n_err), 32'd0);

    // Both masters, three transfers each, slave always ready
    reset = 1'b1; cycle(); reset = 1'b0;
    reset_mon();
    rem0 = 3; rem1 = 3;
    m0_valid = 1'b1; m1_valid = 1'b1; m0_addr = 32'h100; m1_addr = 32'h200;
    s_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      s_rdata = $urandom;
      cycle();
      if (e_rdy0) rem0--;
      if (e_rdy1) rem1--;
      m0_valid = (rem0 > 0);
      m1_valid = (rem1 > 0);
    end
    s_ready = 1'b0;
    for (int i = 0; i < 13; i++) chk($sformatf("rr_grant_%0d", i), 32'(glog[i]), 32'(EXP31[i]));
    chk("rr_m0_done", 32'(n_r0), 32'd3);
    chk("rr_m1_done", 32'(n_r1), 32'd3);

    // m1 byte-masked write passes through unchanged
    reset_mon();
    m1_valid = 1'b1; m1_addr = 32'h0002_0004; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
    cycle();
    cycle();
    s_ready = 1'b1;
    cycle();
    m1_valid = 1'b0; s_ready = 1'b0;
    cycle();
    chk("wr_s_addr", cap_addr, 32'h0002_0004);
    chk("wr_s_wdata", cap_wdata, 32'h1234_5678);
    chk("wr_s_wstrb", 32'(cap_wstrb), 32'h3);
    chk("wr_grant10_cycles", 32'(n_g1), 32'd2);

    // Slave never ready: timeout on the 4th BUSY cycle
    reset_mon();
    m0_valid = 1'b1; m0_addr = 32'h0000_3000;
    cycle();
    for (int i = 0; i < 4; i++) cycle();
    m0_valid = 1'b0;
    cycle(); cycle();
    chk("to_bus_err_pulses", 32'(n_err), 32'd1);
    chk("to_m0_ready_pulses", 32'(n_r0), 32'd1);
    chk("to_m0_rdata", cap_rd0, 32'hFFFF_FFFF);
    chk("to_grant01_cycles", 32'(n_g0), 32'd4);
    chk("to_back_to_idle", 32'(glog[5]), 32'd0);

    // Reset during the 2nd BUSY1 cycle, then a tie
    reset_mon();
    m1_valid = 1'b1; m1_addr = 32'h0000_4000;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; m0_valid = 1'b1;
    cycle();
    cycle();
    for (int i = 0; i < 5; i++) chk($sformatf("rst_grant_%0d", i), 32'(glog[i]), 32'(EXP35[i]));
    chk("rst_no_ready", 32'(n_r0 + n_r1), 32'd0);
    chk("rst_no_err", 32'(n_err), 32'd0);

    // m0 drops its request mid-transfer while the slave is ready
    reset_mon();
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b1;
    cycle(); cycle();
    chk("drop_no_ready", 32'(n_r0 + n_r1), 32'd0);
    chk("drop_no_err", 32'(n_err), 32'd0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      s_ready = ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;
      reset   = ($urandom_range(0, 199) == 0);
      if (!m0_valid) begin
        if ($urandom_range(0, 1) == 1) begin
          m0_valid = 1'b1; m0_addr = $urandom; m0_wdata = $urandom;
          m0_wstrb = 4'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 39) == 0) m0_valid = 1'b0;
      if (!m1_valid) begin
        if ($urandom_range(0, 1) == 1) begin
          m1_valid = 1'b1; m1_addr = $urandom; m1_wdata = $urandom;
          m1_wstrb = 4'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 39) == 0) m1_valid = 1'b0;
      cycle();
      if (e_rdy0) m0_valid = 1'b0;
      if (e_rdy1) m1_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
